prbs_ext_64_chk_ctrl: RTL and testbench

//  Control and compare stage for the 64-bit PRBS31 (x31+x28, XNOR) checker. Sits between the GTF RX

---
 rtl/prbs_chk_pkg.sv | 30 +++
 rtl/prbs_popcount_64.sv | 21 ++
 rtl/prbs_ext_64_chk_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_prbs_ext_64_chk_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_chk_pkg.sv
// Shared types and constants for the 64-bit PRBS31 checker control stage.
// Popcount helper used by the registered error counter.
package prbs_chk_pkg;

  localparam int DATA_W      = 64;
  localparam int NERR_W      = 7;
  localparam int SETTLE_CLKS = 3;
  localparam int DROP_CLKS   = 2;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SETTLE,
    CHECK,
    LOCKED,
    DROP
  } state_t;

  function automatic logic [NERR_W-1:0] popcnt(
    input logic [DATA_W-1:0] v
  );
    logic [NERR_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = c + NERR_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs_popcount_64.sv
// Registered 64-bit population count of the compare error vector.
// Captures only when the compare slot is valid.
module prbs_popcount_64
  import prbs_chk_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [NERR_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= popcnt(data);
    end
  end

endmodule

// File: rtl/prbs_ext_64_chk_ctrl.sv
// PRBS31 checker control: seed delay line, generator sync/CE,
// compare pipeline, lock FSM and saturating statistics.
module prbs_ext_64_chk_ctrl
  import prbs_chk_pkg::*;
#(
  parameter int LOCK_WORDS = 16,
  parameter int LOSS_WORDS = 8,
  parameter int CNT_W      = 48
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] prbs_q,
  output logic              prbs_ce,
  output logic              prbs_sync,
  output logic [DATA_W-1:0] syncdatain_dly0,
  output logic [DATA_W-1:0] syncdatain_dly1,
  output logic [DATA_W-1:0] syncdatain_dly2,
  output logic              locked,
  output logic              lock_lost,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic [31:0]       word_err_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [15:0]       relock_cnt
);

  localparam int RUN_MAX =
    (LOCK_WORDS > LOSS_WORDS) ? LOCK_WORDS : LOSS_WORDS;
  localparam int RUN_W = $clog2(RUN_MAX + 1);

  state_t            state, state_n;
  logic [RUN_W-1:0]  run, run_n;
  logic [1:0]        tmr, tmr_n;
  logic              cmp_v, nv;
  logic [NERR_W-1:0] nerr;
  logic              bad;
  logic              lost_ev;
  logic              upd;
  logic [CNT_W:0]    bit_sum;

  assign prbs_ce = rx_valid;
  assign locked  = (state == LOCKED);
  assign bad     = (nerr != '0);
  assign upd     = nv && (state == LOCKED);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      syncdatain_dly0 <= '0;
      syncdatain_dly1 <= '0;
      syncdatain_dly2 <= '0;
    end else if (rx_valid) begin
      syncdatain_dly0 <= rx_data;
      syncdatain_dly1 <= syncdatain_dly0;
      syncdatain_dly2 <= syncdatain_dly1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_v <= 1'b0;
      nv    <= 1'b0;
    end else begin
      cmp_v <= rx_valid;
      nv    <= cmp_v;
    end
  end

  prbs_popcount_64 u_pop (
    .clk  (clk),
    .rstn (rstn),
    .en   (cmp_v),
    .data (prbs_q ^ syncdatain_dly2),
    .cnt  (nerr)
  );

  always_comb begin
    state_n = state;
    run_n   = run;
    tmr_n   = '0;
    lost_ev = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_n = SYNC;
      end
      SYNC: begin
        state_n = SETTLE;
      end
      SETTLE: begin
        tmr_n = tmr + 2'd1;
        run_n = '0;
        if (tmr == 2'(SETTLE_CLKS - 1)) begin
          state_n = CHECK;
          tmr_n   = '0;
        end
      end
      CHECK: begin
        if (nv && bad) begin
          state_n = DROP;
        end else if (run == RUN_W'(LOCK_WORDS)) begin
          state_n = LOCKED;
          run_n   = '0;
        end else if (nv) begin
          run_n = run + 1'b1;
        end
      end
      LOCKED: begin
        if (nv) begin
          if (!bad) begin
            run_n = '0;
          end else if (run == RUN_W'(LOSS_WORDS - 1)) begin
            state_n = DROP;
            lost_ev = 1'b1;
          end else begin
            run_n = run + 1'b1;
          end
        end
      end
      DROP: begin
        tmr_n = tmr + 2'd1;
        if (tmr == 2'(DROP_CLKS - 1)) begin
          state_n = SYNC;
          tmr_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n = IDLE;
      lost_ev = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      run       <= '0;
      tmr       <= '0;
      prbs_sync <= 1'b0;
    end else begin
      state     <= state_n;
      run       <= run_n;
      tmr       <= tmr_n;
      prbs_sync <= (state_n == SETTLE) ||
                   (state_n == CHECK)  ||
                   (state_n == LOCKED);
    end
  end

  assign bit_sum = {1'b0, bit_err_cnt} +
                   {{(CNT_W + 1 - NERR_W){1'b0}}, nerr};

  // Statistics saturate; clear overrides any same-cycle update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_err_cnt  <= '0;
      word_err_cnt <= '0;
      word_cnt     <= '0;
      relock_cnt   <= '0;
      lock_lost    <= 1'b0;
    end else if (clear) begin
      bit_err_cnt  <= '0;
      word_err_cnt <= '0;
      word_cnt     <= '0;
      relock_cnt   <= '0;
      lock_lost    <= 1'b0;
    end else begin
      if (upd) begin
        bit_err_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        if (bad && !(&word_err_cnt)) begin
          word_err_cnt <= word_err_cnt + 32'd1;
        end
        if (!(&word_cnt)) begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
      if (lost_ev) begin
        lock_lost <= 1'b1;
        if (!(&relock_cnt)) begin
          relock_cnt <= relock_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_ext_64_chk_ctrl.sv
// Directed bench: behavioural PRBS31 generator plus a bit-serial
// reference stream drive the checker control stage.
module tb_prbs_ext_64_chk_ctrl;

  localparam int CNT_W = 48;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic [63:0]      rx_data = '0;
  logic             rx_valid = 1'b0;
  logic [63:0]      prbs_q;
  logic             prbs_ce;
  logic             prbs_sync;
  logic [63:0]      dly0, dly1, dly2;
  logic             locked;
  logic             lock_lost;
  logic [CNT_W-1:0] bit_err_cnt;
  logic [31:0]      word_err_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [15:0]      relock_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  logic [30:0] ref_st = 31'h1234_567;
  logic [94:0] gw;
  logic        s1, s2;

  always #5 clk = ~clk;

  prbs_ext_64_chk_ctrl #(
    .LOCK_WORDS (16),
    .LOSS_WORDS (8),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .enable          (enable),
    .clear           (clear),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .prbs_q          (prbs_q),
    .prbs_ce         (prbs_ce),
    .prbs_sync       (prbs_sync),
    .syncdatain_dly0 (dly0),
    .syncdatain_dly1 (dly1),
    .syncdatain_dly2 (dly2),
    .locked          (locked),
    .lock_lost       (lock_lost),
    .bit_err_cnt     (bit_err_cnt),
    .word_err_cnt    (word_err_cnt),
    .word_cnt        (word_cnt),
    .relock_cnt      (relock_cnt)
  );

  // Generator window: Q in [94:31], next 31 line bits in [30:0].
  function automatic logic [94:0] gen_adv(input logic [94:0] w);
    for (int i = 0; i < 64; i++) begin
      w = {w[93:0], ~(w[30] ^ w[27])};
    end
    return w;
  endfunction

  assign prbs_q = gw[94:31];

  // Load edge is the 2nd edge after sync rises; all-ones tail escapes lockup.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gw <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= prbs_sync;
      s2 <= s1;
      if (s1 && !s2) begin
        gw <= {dly1, (&dly0[63:33]) ? 31'h0 : dly0[63:33]};
      end else if (prbs_sync && prbs_ce) begin
        gw <= gen_adv(gw);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_word(output logic [63:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      b = ~(ref_st[30] ^ ref_st[27]);
      ref_st = {ref_st[29:0], b};
      w = {w[62:0], b};
    end
  endtask

  task automatic send_raw(input logic [63:0] d, input logic v);
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] mask, input logic v);
    logic [63:0] w;
    w = rx_data;
    if (v) begin
      next_word(w);
      w = w ^ mask;
    end
    send_raw(w, v);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) send(64'h0, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    send(64'h0, 1'b0);
    clear = 1'b0;
  endtask

  task automatic run_until_lock(input int lim, input int dens,
                                output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      send(64'h0, $urandom_range(0, 99) < dens);
      if (locked) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int sync_cyc, lock_cyc, cyc, nsent, rises;
    logic fell, seen, prev;

    rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_sync", prbs_sync, 0);
    chk("rst_dly2", dly2, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_ce_follows", prbs_ce, 1);
    rstn = 1'b1;

    // Clean stream, enable rises now
    for (int i = 0; i < 5; i++) send(64'h0, 1'b1);
    enable   = 1'b1;
    sync_cyc = -1;
    lock_cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      send(64'h0, 1'b1);
      if (prbs_sync && sync_cyc < 0) sync_cyc = k;
      if (locked && lock_cyc < 0) lock_cyc = k;
    end
    chk("sync_rise_clk", sync_cyc, 2);
    chk("lock_in_22_24", (lock_cyc >= 22) && (lock_cyc <= 24), 1);

    drain();
    do_clear();
    for (int i = 0; i < 1000; i++) send(64'h0, 1'b1);
    drain();
    chk("w1000_cnt", word_cnt, 1000);
    chk("w1000_bits", bit_err_cnt, 0);
    chk("w1000_werr", word_err_cnt, 0);
    chk("w1000_locked", locked, 1);

    // Single-bit then full-word errors
    do_clear();
    for (int i = 0; i < 10; i++) send(64'h0, 1'b1);
    send(64'h20, 1'b1);
    for (int i = 0; i < 10; i++) send(64'h0, 1'b1);
    drain();
    chk("bit5_bits", bit_err_cnt, 1);
    chk("bit5_werr", word_err_cnt, 1);
    chk("bit5_locked", locked, 1);
    for (int i = 0; i < 5; i++) send(64'h0, 1'b1);
    send('1, 1'b1);
    for (int i = 0; i < 5; i++) send(64'h0, 1'b1);
    drain();
    chk("inv_bits", bit_err_cnt, 65);
    chk("inv_werr", word_err_cnt, 2);
    chk("inv_wcnt", word_cnt, 32);
    chk("inv_locked", locked, 1);

    // Loss of lock and relock
    for (int i = 0; i < 8; i++) send('1, 1'b1);
    fell = 1'b0;
    cyc  = -1;
    for (int i = 1; i <= 30; i++) begin
      send(64'h0, 1'b1);
      if (!locked) fell = 1'b1;
      if (fell && locked) begin
        cyc = i;
        break;
      end
    end
    chk("loss_fell", fell, 1);
    chk("relock_30", cyc > 0, 1);
    chk("loss_sticky", lock_lost, 1);
    chk("loss_relock_cnt", relock_cnt, 1);
    fell = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send('1, 1'b1);
      if (!locked) fell = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      send(64'h0, 1'b1);
      if (!locked) fell = 1'b1;
    end
    chk("seven_hold", fell, 0);
    chk("seven_relock_cnt", relock_cnt, 1);

    // 70% valid density
    enable = 1'b0;
    send(64'h0, 1'b1);
    send(64'h0, 1'b1);
    chk("dis_sync", prbs_sync, 0);
    enable = 1'b1;
    run_until_lock(500, 70, cyc);
    chk("d70_lock", cyc > 0, 1);
    drain();
    do_clear();
    nsent = 0;
    fell  = 1'b0;
    while (nsent < 10000) begin
      logic v;
      v = ($urandom_range(0, 9) < 7);
      send(64'h0, v);
      if (v) nsent++;
      if (!locked) fell = 1'b1;
    end
    drain();
    chk("d70_wcnt", word_cnt, 10000);
    chk("d70_bits", bit_err_cnt, 0);
    chk("d70_werr", word_err_cnt, 0);
    chk("d70_held", fell, 0);

    // All-ones lockup stream
    enable = 1'b0;
    for (int i = 0; i < 3; i++) send_raw('1, 1'b1);
    do_clear();
    enable = 1'b1;
    seen  = 1'b0;
    rises = 0;
    prev  = prbs_sync;
    for (int i = 0; i < 300; i++) begin
      send_raw('1, 1'b1);
      if (locked) seen = 1'b1;
      if (prbs_sync && !prev) rises++;
      prev = prbs_sync;
    end
    chk("ones_nolock", seen, 0);
    chk("ones_sync_toggles", rises >= 3, 1);
    chk("ones_bits", bit_err_cnt, 0);
    chk("ones_wcnt", word_cnt, 0);
    chk("ones_werr", word_err_cnt, 0);

    // Clear and async reset while locked
    enable = 1'b0;
    for (int i = 0; i < 3; i++) send(64'h0, 1'b1);
    enable = 1'b1;
    run_until_lock(100, 100, cyc);
    chk("t6_lock", cyc > 0, 1);
    send(64'h3, 1'b1);
    for (int i = 0; i < 3; i++) send(64'h0, 1'b1);
    for (int i = 0; i < 8; i++) send('1, 1'b1);
    for (int i = 0; i < 5; i++) send(64'h0, 1'b1);
    run_until_lock(40, 100, cyc);
    chk("t6_relock", cyc > 0, 1);
    chk("t6_pre_lost", lock_lost, 1);
    chk("t6_pre_relock", relock_cnt, 1);
    chk("t6_pre_bits_nz", bit_err_cnt != 0, 1);
    clear = 1'b1;
    send(64'h0, 1'b1);
    clear = 1'b0;
    chk("clr_bits", bit_err_cnt, 0);
    chk("clr_werr", word_err_cnt, 0);
    chk("clr_wcnt", word_cnt, 0);
    chk("clr_relock", relock_cnt, 0);
    chk("clr_lost", lock_lost, 0);
    chk("clr_locked", locked, 1);
    for (int i = 0; i < 3; i++) send(64'h0, 1'b1);
    chk("pre_rst_wcnt", word_cnt, 3);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_sync", prbs_sync, 0);
    chk("arst_dly0", dly0, 0);
    chk("arst_dly2", dly2, 0);
    chk("arst_wcnt", word_cnt, 0);
    chk("arst_bits", bit_err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
